// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: control-bundle bit offsets and buffer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

   // Bit offsets inside the control bundle carried alongside each payload
   localparam int CTRL_MEMREAD  = 0;
   localparam int CTRL_MEMWRITE = 1;
   localparam int CTRL_REGWRITE = 2;
   localparam int CTRL_MEMTOREG = 3;
   localparam int CTRL_PCSRC    = 4;   // two bits: [5:4]
   localparam int CTRL_PCSRC_W  = 2;
   localparam int CTRL_WWD      = 6;
   localparam int CTRL_DONE     = 7;

   // Stage buffer occupancy states; SKID means main and skid registers both hold beats
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_warmup_ctr.sv
// Post-reset hold: counts WARMUP clock edges after reset release, then raises warm.
// Latency: warm rises WARMUP edges after reset_n deasserts (immediately when WARMUP=0).
// Backpressure: none; consumers gate their ready with warm.
module pipe_warmup_ctr #(
   parameter int WARMUP = 2
) (
   input  logic clk,
   input  logic reset_n,
   output logic warm
);

   localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
   localparam logic [CW-1:0] LIMIT = CW'(WARMUP);

   logic [CW-1:0] cnt;

   // Count up to the limit, then saturate so warm stays high until the next reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (cnt < LIMIT) begin
         cnt <= cnt + CW'(1);
      end
   end

   // Qualifying with reset_n keeps warm low during reset even when WARMUP=0
   assign warm = reset_n & (cnt == LIMIT);

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register: payload + control between stages with valid/ready, optional 2-entry skid, flush to bubble.
// Latency: 1 cycle (beat accepted at edge N is presented after edge N); 1 beat/cycle sustained.
// Backpressure: SKID=1 in_ready is registered (no out_ready path); SKID=0 in_ready = warm & (!full | out_ready), combinational.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 10,
   parameter int WARMUP = 2,
   parameter int SKID   = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic              warm
);

   pipe_state_t       state;
   pipe_state_t       state_nxt;

   logic              accept;
   logic              emit;
   logic              main_vld;
   logic              skid_vld;
   logic              main_load_in;
   logic              main_load_skid;
   logic              skid_load;

   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   pipe_warmup_ctr #(
      .WARMUP (WARMUP)
   ) u_warmup (
      .clk     (clk),
      .reset_n (reset_n),
      .warm    (warm)
   );

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   generate
      if (SKID != 0) begin : g_ready_skid
         // Ready depends only on registered state, breaking the out_ready -> in_ready chain
         assign in_ready = warm & (state != ST_SKID);
      end else begin : g_ready_single
         // Single entry: can refill in the same cycle it drains, so ready looks through out_ready
         assign in_ready = warm & (~main_vld | out_ready);
      end
   endgenerate

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: flush wins over any accept/emit; SKID is only reachable with the skid buffer present
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
               if (accept && !emit) begin
                  state_nxt = (SKID != 0) ? ST_SKID : ST_FULL;
               end else if (!accept && emit) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_SKID:  if (emit) state_nxt = ST_FULL;
            default:  state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Outputs decoded from state and the head register; control is zeroed on bubbles
   always_comb begin
      main_vld  = (state != ST_EMPTY);
      skid_vld  = (state == ST_SKID);
      out_valid = main_vld;
      out_data  = main_data;
      out_ctrl  = main_vld ? main_ctrl : '0;
      occupancy = 2'(main_vld) + 2'(skid_vld);
   end

   // Register load enables; a flushed cycle loads nothing so out_data keeps its last payload
   always_comb begin
      main_load_in   = 1'b0;
      main_load_skid = 1'b0;
      skid_load      = 1'b0;
      if (!flush) begin
         main_load_in   = accept & ((state == ST_EMPTY) | ((state == ST_FULL) & emit));
         main_load_skid = emit & (state == ST_SKID);
         skid_load      = (SKID != 0) & accept & (state == ST_FULL) & ~emit;
      end
   end

   // Main (head) register: takes the incoming beat or the promoted skid entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_data <= '0;
         main_ctrl <= '0;
      end else if (main_load_in) begin
         main_data <= in_data;
         main_ctrl <= in_ctrl;
      end else if (main_load_skid) begin
         main_data <= skid_data;
         main_ctrl <= skid_ctrl;
      end
   end

   generate
      if (SKID != 0) begin : g_skid_reg
         // Skid register: catches the beat that arrives while the head is stalled
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               skid_data <= '0;
               skid_ctrl <= '0;
            end else if (skid_load) begin
               skid_data <= in_data;
               skid_ctrl <= in_ctrl;
            end
         end
      end else begin : g_no_skid
         assign skid_data = '0;
         assign skid_ctrl = '0;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf (SKID=1, WARMUP=2): accepted beats queue expected values,
// a negedge monitor pops and compares on every emitted beat and checks bubble gating,
// directed steps check warm-up, streaming, back-pressure, flush, and async reset.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   localparam int DW = 64;
   localparam int CW = 10;

   logic          clk       = 1'b0;
   logic          reset_n   = 1'b1;
   logic          flush     = 1'b0;
   logic          in_valid  = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data   = '0;
   logic [CW-1:0] in_ctrl   = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic          warm;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } beat_t;

   beat_t sb[$];
   int    errors = 0;
   int    checks = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(
      .DATA_W (DW),
      .CTRL_W (CW),
      .WARMUP (2),
      .SKID   (1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy),
      .warm      (warm)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Distinct, always non-zero control bundle per payload
   function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] dv);
      logic [CW-1:0] c;
      c = '0;
      c[CTRL_PCSRC +: CTRL_PCSRC_W] = dv[1:0];
      c[CTRL_MEMREAD]  = dv[2];
      c[CTRL_MEMWRITE] = dv[3];
      c[CTRL_REGWRITE] = 1'b1;
      c[CTRL_MEMTOREG] = dv[4];
      c[CTRL_WWD]      = dv[5];
      c[CTRL_DONE]     = 1'b1;
      return c;
   endfunction

   // One clock cycle of stimulus; queues the expected beat when it is accepted and not flushed
   task automatic step(input logic v, input logic [DW-1:0] dv, input logic [CW-1:0] cv,
                       input logic ordy, input logic fl, output logic acc);
      in_valid  = v;
      in_data   = dv;
      in_ctrl   = cv;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      acc = v & in_ready;
      if (acc && !fl) sb.push_back(beat_t'{d: dv, c: cv});
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic v, input logic [DW-1:0] dv, input logic ordy,
                     input logic fl, output logic acc);
      step(v, dv, mk_ctrl(dv), ordy, fl, acc);
   endtask

   // Monitor: compare every emitted beat against the scoreboard; control must be zero on bubbles
   beat_t exp_beat;
   always @(negedge clk) begin
      if (reset_n) begin
         if (!out_valid) chk("bubble_ctrl", 64'(out_ctrl), 64'h0);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", out_data);
            end else begin
               exp_beat = sb.pop_front();
               chk("emit_data", out_data, exp_beat.d);
               chk("emit_ctrl", 64'(out_ctrl), 64'(exp_beat.c));
            end
         end
      end
   end

   initial begin
      logic acc;

      // Reset state
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready",  64'(in_ready),  64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_ctrl",  64'(out_ctrl),  64'h0);
      chk("rst_out_data",  out_data,       64'h0);
      chk("rst_occupancy", 64'(occupancy), 64'h0);
      chk("rst_warm",      64'(warm),      64'h0);

      // Warm-up: two refused cycles, accept on the third, valid on the fourth
      reset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         go(1'b1, 64'h55, 1'b1, 1'b0, acc);
         chk($sformatf("warmup_accept_c%0d", i), 64'(acc), (i == 3) ? 64'h1 : 64'h0);
      end
      chk("warm_after",      64'(warm),      64'h1);
      chk("first_out_valid", 64'(out_valid), 64'h1);

      // Streaming 1..8 with out_ready held high
      for (int i = 1; i <= 8; i++) begin
         go(1'b1, 64'(i), 1'b1, 1'b0, acc);
         chk("stream_accept",    64'(acc),       64'h1);
         chk("stream_occupancy", 64'(occupancy), 64'h1);
      end
      go(1'b0, 64'h0, 1'b1, 1'b0, acc);
      chk("drain_occupancy", 64'(occupancy), 64'h0);
      chk("drain_out_valid", 64'(out_valid), 64'h0);

      // Back-pressure: A and B held, C stalled, then all three drain in order
      go(1'b1, 64'hA, 1'b0, 1'b0, acc);
      chk("bp_occ_a", 64'(occupancy), 64'h1);
      go(1'b1, 64'hB, 1'b0, 1'b0, acc);
      chk("bp_occ_b",      64'(occupancy), 64'h2);
      chk("bp_in_ready_0", 64'(in_ready),  64'h0);
      go(1'b1, 64'hC, 1'b0, 1'b0, acc);
      chk("bp_c_stalled", 64'(acc),       64'h0);
      chk("bp_occ_hold",  64'(occupancy), 64'h2);
      go(1'b1, 64'hC, 1'b1, 1'b0, acc);
      chk("bp_c_still_stalled", 64'(acc),       64'h0);
      chk("bp_in_ready_back",   64'(in_ready),  64'h1);
      chk("bp_occ_after_emit",  64'(occupancy), 64'h1);
      go(1'b1, 64'hC, 1'b1, 1'b0, acc);
      chk("bp_c_accept", 64'(acc), 64'h1);
      go(1'b0, 64'h0, 1'b1, 1'b0, acc);
      chk("bp_occ_empty", 64'(occupancy), 64'h0);

      // Flush with two held and 0xD offered
      go(1'b1, 64'h11, 1'b0, 1'b0, acc);
      go(1'b1, 64'h12, 1'b0, 1'b0, acc);
      chk("fl_occ_full", 64'(occupancy), 64'h2);
      go(1'b1, 64'hD, 1'b0, 1'b1, acc);
      sb.delete();
      chk("fl_out_valid", 64'(out_valid), 64'h0);
      chk("fl_out_ctrl",  64'(out_ctrl),  64'h0);
      chk("fl_occupancy", 64'(occupancy), 64'h0);
      chk("fl_in_ready",  64'(in_ready),  64'h1);
      go(1'b0, 64'h0, 1'b1, 1'b0, acc);
      chk("fl_stays_empty", 64'(out_valid), 64'h0);

      // Flush colliding with an accept: incoming 0x22 is dropped
      go(1'b1, 64'h21, 1'b0, 1'b0, acc);
      go(1'b1, 64'h22, 1'b0, 1'b1, acc);
      sb.delete();
      chk("fl_acc_occupancy", 64'(occupancy), 64'h0);
      chk("fl_acc_out_valid", 64'(out_valid), 64'h0);

      // Flush colliding with an emit: 0x31 is still consumed, 0x32 dropped
      go(1'b1, 64'h31, 1'b0, 1'b0, acc);
      go(1'b1, 64'h32, 1'b1, 1'b1, acc);
      chk("fl_emit_consumed", 64'(sb.size()), 64'h0);
      chk("fl_emit_occ",      64'(occupancy), 64'h0);

      // Bubble gating: full control bundle passes, then zero while data holds
      step(1'b1, 64'h77, 10'h3FF, 1'b1, 1'b0, acc);
      go(1'b0, 64'h0, 1'b1, 1'b0, acc);
      chk("bub_out_valid", 64'(out_valid), 64'h0);
      chk("bub_out_ctrl",  64'(out_ctrl),  64'h0);
      chk("bub_out_data",  out_data,       64'h77);

      // Async reset between edges with two beats held
      go(1'b1, 64'h41, 1'b0, 1'b0, acc);
      go(1'b1, 64'h42, 1'b0, 1'b0, acc);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_occupancy", 64'(occupancy), 64'h0);
      chk("arst_in_ready",  64'(in_ready),  64'h0);
      chk("arst_warm",      64'(warm),      64'h0);
      chk("arst_out_ctrl",  64'(out_ctrl),  64'h0);
      chk("arst_out_data",  out_data,       64'h0);
      sb.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         go(1'b1, 64'h43, 1'b1, 1'b0, acc);
         chk($sformatf("rewarm_accept_c%0d", i), 64'(acc), (i == 3) ? 64'h1 : 64'h0);
      end
      repeat (2) go(1'b0, 64'h0, 1'b1, 1'b0, acc);
      chk("sb_drained", 64'(sb.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
